rgb_gray_stream: RTL
====================

# rgb_gray_stream

Streaming colour-to-grayscale converter, parametrised in sample width, frame size and conversion mode. Sits between the frame-buffer read port and the downstream grayscale buffer. Accepts byte-serial R,G,B samples over a valid/ready handshake and emits one gray sample per pixel over a second valid/ready handshake. Signals frame completion to the controller.

## Interface
- `DW`, 8, sample width in bits (R, G, B and gray).
- `IMG_W`, 2, frame width in pixels.
- `IMG_H`, 2, frame height in pixels.
- `clk`  in  1  clock; all logic on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle request to convert one frame; honoured only in IDLE.
- `mode`  in  2  conversion mode, latched on accepted `start`: 0 = luma approx., 1 = weighted average, 2 = max, 3 = reserved (behaves as 0).
- `in_data`  in  DW  channel sample; order per pixel R, G, B.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `out_data`  out  DW  gray sample.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accepts `out_data`.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at end of frame.

## Operation
- Input handshake: sample transfers on a cycle with `in_valid && in_ready`. Output handshake: transfers on a cycle with `out_valid && out_ready`.
- States:
  - IDLE: `in_ready`=0; `start` -> RUN. Latch `mode`, clear channel index `ch` (0..2) and pixel counter `pix` (0..IMG_W*IMG_H-1).
  - RUN: input handshakes store R (`ch`=0) and G (`ch`=1), then advance `ch`. The B handshake (`ch`=2) computes gray from stored R, G and `in_data`. It loads gray into the output register, sets `out_valid`, wraps `ch` to 0 and increments `pix`. After the B of the last pixel -> DRAIN.
  - DRAIN: `in_ready`=0; wait for the output handshake of the last pixel -> DONE.
  - DONE: `done`=1 for one cycle, `busy` drops -> IDLE.
- `in_ready` in RUN = !(`ch`==2 && `out_valid` && !`out_ready`). R and G are never stalled. B is stalled only if it would overwrite an unconsumed result.
- `out_valid` clears on an output handshake unless a B handshake in the same cycle reloads the register; a reload keeps it high.
- Arithmetic:
  - Intermediate sums use DW+2 bits; the result is truncated to DW bits.
  - Mode 0: `(R>>2)+(R>>5)+(G>>1)+(G>>4)+(B>>4)+(B>>5)`, each term truncated individually. Coefficients sum to 15/16, so there is no overflow.
  - Mode 1: `(R+2G+B)>>2`.
  - Mode 2: `max(R,G,B)`.
- `start` while not IDLE is ignored. `mode` changes mid-frame have no effect.
- `in_data` values are ignored when `in_ready`=0 or `in_valid`=0.
- Reset at any time aborts the frame: the state returns to IDLE and the partial pixel is discarded.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0; `ch`=0, `pix`=0; state IDLE.
- Accepted `start` at edge k: `busy`=1 and `in_ready`=1 from cycle k+1.
- Latency: B handshake at edge k -> `out_valid`=1 with `out_data` valid in cycle k+1.
- Peak throughput: one pixel per 3 cycles with `out_ready` tied high, with no input bubbles.
- `out_data` holds stable while `out_valid && !out_ready`.
- Last output handshake at edge k -> `done`=1 in cycle k+1, `busy`=0 in cycle k+2.
- A new `start` is accepted from cycle k+2, back-to-back with the prior frame.

## Test plan
- Mode 0, defaults: pixel (200,100,50), `out_ready`=1 -> `out_data`=116 one cycle after B. Pixel (255,255,255) -> 234. Pixel (0,0,0) -> 0.
- Mode 1: (200,100,50) -> 112. Mode 2: (200,100,50) -> 200. Mode 3: (200,100,50) -> 116.
- Full frame, 4 pixels, continuous `in_valid`, `out_ready`=1 -> four outputs spaced 3 cycles apart; `done` pulses once, one cycle after the 4th output; `busy` low the next cycle.
- Backpressure: `out_ready`=0 for 10 cycles after the first output -> R and G of pixel 2 accepted, `in_ready`=0 at B, `out_data` stable. Releasing `out_ready` -> B accepted in the same cycle; no sample lost or duplicated.
- `start` pulsed mid-frame and `mode` toggled mid-frame -> no effect on the outputs or the pixel count.
- `rst` asserted after G of pixel 3 -> all outputs at reset values next cycle. A new `start` then converts a full 4-pixel frame correctly from R.

Source files
------------

// File: rtl/rgb_gray_stream_if.sv
// Single valid/ready sample stream: one direction of the converter's data path.
interface rgb_gray_stream_if #(
  parameter int DW = 8
);
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;

  // Producer side of the stream.
  modport master (output data, output valid, input ready);

  // Consumer side of the stream.
  modport slave (input data, input valid, output ready);
endinterface

// File: rtl/rgb_gray_stream.sv
// Streaming colour-to-grayscale converter.
// Takes byte-serial R,G,B samples on one stream and emits one gray sample per
// pixel on another. It converts exactly one frame per accepted start and pulses
// done once the last gray sample has been taken downstream.
module rgb_gray_stream #(
  parameter int DW    = 8,
  parameter int IMG_W = 2,
  parameter int IMG_H = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  rgb_gray_stream_if.slave    in_s,
  rgb_gray_stream_if.master   out_s,
  output logic                busy,
  output logic                done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int SW   = DW + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    mode_q;
  logic [1:0]    ch;
  logic [PW-1:0] pix;
  logic [DW-1:0] r_q;
  logic [DW-1:0] g_q;
  logic [DW-1:0] out_data_q;
  logic          out_valid_q;
  logic [DW-1:0] gray;
  logic [DW-1:0] mx;
  logic [SW-1:0] r_x;
  logic [SW-1:0] g_x;
  logic [SW-1:0] b_x;
  logic          in_ready;
  logic          in_hs;
  logic          b_hs;
  logic          out_hs;
  logic          last_pix;

  // The blue sample is the only one held back: it would overwrite a result
  // that downstream has not taken yet. Red and green always go straight in.
  assign in_ready = (state == RUN) && !(ch[1] && out_valid_q && !out_s.ready);
  assign in_hs    = in_s.valid && in_ready;
  assign b_hs     = in_hs && ch[1];
  assign out_hs   = out_valid_q && out_s.ready;
  assign last_pix = (pix == PW'(NPIX - 1));

  assign in_s.ready  = in_ready;
  assign out_s.data  = out_data_q;
  assign out_s.valid = out_valid_q;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  // Gray value for the pixel whose blue sample is on the input right now.
  // Operands are widened by two bits so the weighted sum cannot wrap before the
  // final truncation back to the sample width.
  always_comb begin
    r_x = SW'(r_q);
    g_x = SW'(g_q);
    b_x = SW'(in_s.data);
    mx  = r_q;
    if (g_q > mx)       mx = g_q;
    if (in_s.data > mx) mx = in_s.data;
    case (mode_q)
      2'd1:    gray = DW'((r_x + (g_x << 1) + b_x) >> 2);
      2'd2:    gray = mx;
      default: gray = DW'((r_x >> 2) + (r_x >> 5) + (g_x >> 1) + (g_x >> 4)
                          + (b_x >> 4) + (b_x >> 5));
    endcase
  end

  // Frame sequencing state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: run until the last blue sample, then wait for it to drain out.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (b_hs && last_pix) state_nxt = DRAIN;
      DRAIN:   if (out_hs) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sample capture, channel/pixel counting and the output holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= 2'd0;
      ch          <= 2'd0;
      pix         <= '0;
      r_q         <= '0;
      g_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        mode_q <= mode;
        ch     <= 2'd0;
        pix    <= '0;
      end
      if (in_hs) begin
        case (ch)
          2'd0: begin
            r_q <= in_s.data;
            ch  <= 2'd1;
          end
          2'd1: begin
            g_q <= in_s.data;
            ch  <= 2'd2;
          end
          default: begin
            out_data_q <= gray;
            ch         <= 2'd0;
            pix        <= pix + PW'(1);
          end
        endcase
      end
      if (b_hs)        out_valid_q <= 1'b1;
      else if (out_hs) out_valid_q <= 1'b0;
    end
  end

endmodule
